// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback slice.
//   REG_ADDR_W / XLEN / NUM_REGS : register file geometry
//   reg_addr_t                   : register index
//   wb_req_t                     : one writeback candidate (valid, rd, value)
//   lbuf_state_t                 : occupancy of the single-entry load buffer
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic            valid;
        reg_addr_t       rd;
        logic [XLEN-1:0] value;
    } wb_req_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } lbuf_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for hazard detection.
//   clk, reset          : clock, async active-high reset (clears all bits)
//   set_en / set_addr   : mark a register busy (issue of a writer)
//   clr_en / clr_addr   : mark a register free (register file commit)
//   rs1/rs2/rd_addr     : combinational lookup addresses
//   busy_rs1/rs2/rd     : busy state of the looked-up registers
// x0 is never busy. If set and clear hit the same register, set wins.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    input  logic [AW-1:0] rd_addr,
    output logic          busy_rs1,
    output logic          busy_rs2,
    output logic          busy_rd
);

    logic [NUM_REGS-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign busy_rs1 = busy_q[rs1_addr];
    assign busy_rs2 = busy_q[rs2_addr];
    assign busy_rd  = busy_q[rd_addr];

endmodule

// File: rtl/regfile_writeback.sv
// Owns the register file write port and merges ALU and load results into it.
//   clk, reset                    : clock, async active-high reset
//   issue_valid/rd/rs1/rs2        : decode candidate; issue_valid marks rd busy
//   issue_stall                   : combinational RAW/WAW hazard on rs1/rs2/rd
//   alu_valid/rd/value            : single-cycle ALU result, always accepted
//   load_valid/ready/rd/value     : multi-cycle load result, valid/ready
//   rf_write_enable/address/value : registered write port to the register file
// Priority each cycle is ALU > buffered load > new load. A load that collides
// with the ALU parks in a one-entry buffer; the ALU never backpressures, so a
// continuous ALU stream can starve the buffered load.
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int XLEN     = regfile_pkg::XLEN
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        issue_valid,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rd,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rs1,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rs2,
    output logic                        issue_stall,
    input  logic                        alu_valid,
    input  logic [$clog2(NUM_REGS)-1:0] alu_rd,
    input  logic [XLEN-1:0]             alu_value,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [$clog2(NUM_REGS)-1:0] load_rd,
    input  logic [XLEN-1:0]             load_value,
    output logic                        rf_write_enable,
    output logic [$clog2(NUM_REGS)-1:0] rf_address_write,
    output logic [XLEN-1:0]             rf_value_write
);

    localparam int AW = $clog2(NUM_REGS);

    lbuf_state_t state_q, state_d;
    wb_req_t     buf_q, buf_d;
    wb_req_t     win;
    logic        busy_rs1, busy_rs2, busy_rd;
    logic        issue_fire;
    logic        win_writes;

    assign load_ready  = (state_q == EMPTY);
    assign issue_stall = busy_rs1 | busy_rs2 | busy_rd;
    assign issue_fire  = issue_valid & ~issue_stall & (issue_rd != '0);

    // Arbitration and load buffer next state.
    always_comb begin
        win     = '0;
        state_d = state_q;
        buf_d   = buf_q;
        if (alu_valid) begin
            win.valid = 1'b1;
            win.rd    = alu_rd;
            win.value = alu_value;
            // Only an empty buffer can accept the colliding load.
            if ((state_q == EMPTY) && load_valid) begin
                buf_d.valid = 1'b1;
                buf_d.rd    = load_rd;
                buf_d.value = load_value;
                state_d     = HELD;
            end
        end else if (state_q == HELD) begin
            win         = buf_q;
            win.valid   = 1'b1;
            buf_d.valid = 1'b0;
            state_d     = EMPTY;
        end else if (load_valid) begin
            win.valid = 1'b1;
            win.rd    = load_rd;
            win.value = load_value;
        end
    end

    // An x0 winner still consumes its slot but never writes.
    assign win_writes = win.valid & (win.rd != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

    // Address/data hold their last written values when nothing is written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_write_enable  <= 1'b0;
            rf_address_write <= '0;
            rf_value_write   <= '0;
        end else begin
            rf_write_enable <= win_writes;
            if (win_writes) begin
                rf_address_write <= win.rd;
                rf_value_write   <= win.value;
            end
        end
    end

    // Busy clears on the same edge the register file commits, so a dependent
    // instruction sees the committed value once the stall drops.
    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (issue_fire),
        .set_addr (issue_rd),
        .clr_en   (rf_write_enable),
        .clr_addr (rf_address_write),
        .rs1_addr (issue_rs1),
        .rs2_addr (issue_rs2),
        .rd_addr  (issue_rd),
        .busy_rs1 (busy_rs1),
        .busy_rs2 (busy_rs2),
        .busy_rd  (busy_rd)
    );

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        issue_stall;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_value;
    logic        load_valid;
    logic        load_ready;
    logic [4:0]  load_rd;
    logic [31:0] load_value;
    logic        rf_write_enable;
    logic [4:0]  rf_address_write;
    logic [31:0] rf_value_write;

    int checks   = 0;
    int failures = 0;

    // Reference model: set of busy registers, FIFO of parked loads, and the
    // write expected to be visible on the port this cycle.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] value;
    } ld_t;

    bit          mbusy [32];
    ld_t         held  [$];
    bit          exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_val;

    always #5 clk = ~clk;

    regfile_writeback dut (
        .clk              (clk),
        .reset            (reset),
        .issue_valid      (issue_valid),
        .issue_rd         (issue_rd),
        .issue_rs1        (issue_rs1),
        .issue_rs2        (issue_rs2),
        .issue_stall      (issue_stall),
        .alu_valid        (alu_valid),
        .alu_rd           (alu_rd),
        .alu_value        (alu_value),
        .load_valid       (load_valid),
        .load_ready       (load_ready),
        .load_rd          (load_rd),
        .load_value       (load_value),
        .rf_write_enable  (rf_write_enable),
        .rf_address_write (rf_address_write),
        .rf_value_write   (rf_value_write)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
        alu_valid   = 1'b0; alu_rd   = '0; alu_value = '0;
        load_valid  = 1'b0; load_rd  = '0; load_value = '0;
    endtask

    task automatic model_reset();
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        held.delete();
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_val  = '0;
    endtask

    // One clock cycle with the inputs already driven (called at posedge+1).
    task automatic cycle();
        bit          w_v, e_stall;
        logic [4:0]  w_rd;
        logic [31:0] w_val;
        ld_t         e;
        #2;
        e_stall = mbusy[issue_rs1] | mbusy[issue_rs2] | mbusy[issue_rd];
        chk("issue_stall", 32'(issue_stall), 32'(e_stall));
        chk("load_ready", 32'(load_ready), 32'(held.size() == 0));
        w_v = 1'b0; w_rd = '0; w_val = '0;
        if (alu_valid) begin
            w_v = 1'b1; w_rd = alu_rd; w_val = alu_value;
            if (load_valid && held.size() == 0) begin
                e.rd = load_rd; e.value = load_value;
                held.push_back(e);
            end
        end else if (held.size() != 0) begin
            e = held.pop_front();
            w_v = 1'b1; w_rd = e.rd; w_val = e.value;
        end else if (load_valid) begin
            w_v = 1'b1; w_rd = load_rd; w_val = load_value;
        end
        @(posedge clk); #1;
        // Committed write frees its register; a new issue marks its rd.
        if (exp_we) mbusy[exp_addr] = 1'b0;
        if (issue_valid && !e_stall && issue_rd != 0) mbusy[issue_rd] = 1'b1;
        exp_we = w_v && (w_rd != 0);
        if (exp_we) begin
            exp_addr = w_rd;
            exp_val  = w_val;
        end
        chk("rf_write_enable", 32'(rf_write_enable), 32'(exp_we));
        if (exp_we || !w_v) begin
            chk("rf_address_write", 32'(rf_address_write), 32'(exp_addr));
            chk("rf_value_write", rf_value_write, exp_val);
        end
    endtask

    initial begin
        set_idle();
        model_reset();

        // Reset state
        reset = 1'b1;
        #2;
        chk("rst_we", 32'(rf_write_enable), 32'd0);
        chk("rst_addr", 32'(rf_address_write), 32'd0);
        chk("rst_value", rf_value_write, 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // ALU latency: issue x3, ALU writes it next cycle
        set_idle(); issue_valid = 1'b1; issue_rd = 5'd3; cycle();
        set_idle(); alu_valid = 1'b1; alu_rd = 5'd3; alu_value = 32'hDEADBEEF; issue_rs1 = 5'd3; cycle();
        chk("alu_lat_we", 32'(rf_write_enable), 32'd1);
        chk("alu_lat_addr", 32'(rf_address_write), 32'd3);
        chk("alu_lat_value", rf_value_write, 32'hDEADBEEF);
        set_idle(); issue_rs1 = 5'd3; cycle();
        set_idle(); issue_rs1 = 5'd3; cycle();

        // Collision: ALU first, load one cycle later
        set_idle(); alu_valid = 1'b1; alu_rd = 5'd4; alu_value = 32'h11;
        load_valid = 1'b1; load_rd = 5'd7; load_value = 32'h22; cycle();
        chk("coll_addr4", 32'(rf_address_write), 32'd4);
        chk("coll_ready0", 32'(load_ready), 32'd0);
        set_idle(); cycle();
        chk("coll_addr7", 32'(rf_address_write), 32'd7);
        chk("coll_value7", rf_value_write, 32'h22);
        set_idle(); cycle();

        // Starvation: ALU busy for 3 cycles holds the load off
        set_idle(); alu_valid = 1'b1; alu_rd = 5'd1; alu_value = 32'hA1;
        load_valid = 1'b1; load_rd = 5'd9; load_value = 32'h99; cycle();
        for (int i = 0; i < 2; i++) begin
            set_idle(); alu_valid = 1'b1; alu_rd = 5'd2; alu_value = 32'hB0 + 32'(i); cycle();
            chk("starve_ready0", 32'(load_ready), 32'd0);
        end
        set_idle(); cycle();
        chk("drain_addr9", 32'(rf_address_write), 32'd9);
        chk("drain_value9", rf_value_write, 32'h99);
        set_idle(); cycle();

        // x0 drop
        set_idle(); alu_valid = 1'b1; alu_rd = 5'd0; alu_value = 32'hFFFFFFFF;
        issue_valid = 1'b1; issue_rd = 5'd0; cycle();
        chk("x0_we", 32'(rf_write_enable), 32'd0);
        set_idle(); cycle();

        // WAW stall on x12
        set_idle(); issue_valid = 1'b1; issue_rd = 5'd12; cycle();
        for (int i = 0; i < 3; i++) begin
            set_idle(); issue_rd = 5'd12; cycle();
        end
        set_idle(); issue_rd = 5'd12; alu_valid = 1'b1; alu_rd = 5'd12; alu_value = 32'hC12; cycle();
        set_idle(); issue_rd = 5'd12; cycle();
        set_idle(); issue_rd = 5'd12; cycle();

        // Reset while a load is HELD and x5 is busy
        set_idle(); issue_valid = 1'b1; issue_rd = 5'd5; cycle();
        set_idle(); alu_valid = 1'b1; alu_rd = 5'd1; alu_value = 32'h1;
        load_valid = 1'b1; load_rd = 5'd6; load_value = 32'h66; cycle();
        set_idle(); alu_valid = 1'b1; alu_rd = 5'd2; alu_value = 32'h2; issue_rs1 = 5'd5;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_load_ready", 32'(load_ready), 32'd1);
        chk("midrst_we", 32'(rf_write_enable), 32'd0);
        chk("midrst_stall", 32'(issue_stall), 32'd0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        set_idle(); issue_rs1 = 5'd5; cycle();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            set_idle();
            issue_valid = ($urandom % 3) == 0;
            issue_rd    = 5'($urandom_range(0, 7));
            issue_rs1   = 5'($urandom_range(0, 7));
            issue_rs2   = 5'($urandom_range(0, 7));
            alu_valid   = ($urandom % 2) == 0;
            alu_rd      = 5'($urandom_range(0, 7));
            alu_value   = $urandom;
            load_valid  = ($urandom % 2) == 0;
            load_rd     = 5'($urandom_range(0, 7));
            load_value  = $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
